// File: rtl/lcd_cmd_engine.sv
// lcd_cmd_engine
//   Responder side of the LCD request/ack command interface. A request latched
//   in IDLE is executed on a 4-bit HD44780-style bus with E/RS timing. Each
//   command ends with a sticky ack that is released by an initlcd pulse.
//
// Ports
//   CCLK                         clock
//   debpb0                       synchronous active-high reset
//   resetlcd/clearlcd/homelcd/
//   addrlcd/datalcd              requests (priority in that order)
//   initlcd                      ack release pulse
//   lcddatin[7:0]                command/data byte
//   lcdreset/lcdclear/lcdhome/
//   lcdaddr/lcddata              per-command acks
//   lcd_e, lcd_rs, lcd_rw, lcd_d LCD bus (lcd_rw tied low)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a request
// S_SETUP | RS/data driven, E low (setup time)
// S_EHIGH | E high
// S_GAP   | E low, RS/data held
// S_WAIT  | command execution wait (also the power-on wait)
// S_ACK   | ack high until initlcd is sampled

module lcd_cmd_engine #(
  parameter int unsigned T_PWR  = 750000,
  parameter int unsigned T_4100 = 205000,
  parameter int unsigned T_100  = 5000,
  parameter int unsigned T_40   = 2000,
  parameter int unsigned T_1640 = 82000,
  parameter int unsigned T_SU   = 2,
  parameter int unsigned T_EH   = 12,
  parameter int unsigned T_NIB  = 50
) (
  input  logic       CCLK,
  input  logic       debpb0,
  input  logic       resetlcd,
  input  logic       clearlcd,
  input  logic       homelcd,
  input  logic       addrlcd,
  input  logic       datalcd,
  input  logic       initlcd,
  input  logic [7:0] lcddatin,
  output logic       lcdreset,
  output logic       lcdclear,
  output logic       lcdhome,
  output logic       lcdaddr,
  output logic       lcddata,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_EHIGH, S_GAP, S_WAIT, S_ACK
  } state_t;

  // Down-counter reload values: a wait of N cycles loads N-1 and ends at zero.
  localparam logic [19:0] L_PWR  = 20'(T_PWR  - 1);
  localparam logic [19:0] L_4100 = 20'(T_4100 - 1);
  localparam logic [19:0] L_100  = 20'(T_100  - 1);
  localparam logic [19:0] L_40   = 20'(T_40   - 1);
  localparam logic [19:0] L_1640 = 20'(T_1640 - 1);
  localparam logic [19:0] L_SU   = 20'(T_SU   - 1);
  localparam logic [19:0] L_EH   = 20'(T_EH   - 1);
  localparam logic [19:0] L_NIB  = 20'(T_NIB  - 1);

  localparam logic [1:0] W_40   = 2'd0;
  localparam logic [1:0] W_1640 = 2'd1;
  localparam logic [1:0] W_4100 = 2'd2;
  localparam logic [1:0] W_100  = 2'd3;

  state_t      state;
  logic [19:0] cnt;
  logic [4:0]  op_r;      // one-hot {reset,clear,home,addr,data}
  logic [4:0]  ack_r;
  logic [7:0]  byte_r;
  logic        nib_only;  // init nibble: only byte_r[3:0] is sent
  logic        hi_phase;  // upper nibble of a byte is on the bus
  logic [1:0]  wsel;
  logic [3:0]  idx;       // next power-on init item; 8 = sequence done

  logic [4:0]  req_sel;
  logic [7:0]  ld_byte;
  logic        ld_nib;
  logic [1:0]  ld_wsel;
  logic        ld_rs;

  // Power-on init items after the T_PWR wait: {nibble_only, wait select, value}.
  function automatic logic [10:0] init_item(input logic [2:0] i);
    case (i)
      3'd0:    init_item = {1'b1, W_4100, 8'h03};
      3'd1:    init_item = {1'b1, W_100,  8'h03};
      3'd2:    init_item = {1'b1, W_40,   8'h03};
      3'd3:    init_item = {1'b1, W_40,   8'h02};
      3'd4:    init_item = {1'b0, W_40,   8'h28};
      3'd5:    init_item = {1'b0, W_40,   8'h06};
      3'd6:    init_item = {1'b0, W_40,   8'h0C};
      default: init_item = {1'b0, W_1640, 8'h01};
    endcase
  endfunction

  function automatic logic [19:0] wait_load(input logic [1:0] w);
    case (w)
      W_40:    wait_load = L_40;
      W_1640:  wait_load = L_1640;
      W_4100:  wait_load = L_4100;
      default: wait_load = L_100;
    endcase
  endfunction

  always_comb begin
    req_sel = 5'b00000;
    if (resetlcd)      req_sel = 5'b10000;
    else if (clearlcd) req_sel = 5'b01000;
    else if (homelcd)  req_sel = 5'b00100;
    else if (addrlcd)  req_sel = 5'b00010;
    else if (datalcd)  req_sel = 5'b00001;
  end

  // Write to load next: the accepted command in IDLE, otherwise the next init item.
  always_comb begin
    ld_byte = 8'h00;
    ld_nib  = 1'b0;
    ld_wsel = W_40;
    ld_rs   = 1'b0;
    if (state == S_IDLE) begin
      if (clearlcd) begin
        ld_byte = 8'h01;
        ld_wsel = W_1640;
      end else if (homelcd) begin
        ld_byte = 8'h02;
        ld_wsel = W_1640;
      end else if (addrlcd) begin
        ld_byte = {1'b1, lcddatin[6:0]};
      end else begin
        ld_byte = lcddatin;
        ld_rs   = 1'b1;
      end
    end else begin
      {ld_nib, ld_wsel, ld_byte} = init_item(idx[2:0]);
    end
  end

  always_ff @(posedge CCLK) begin
    if (debpb0) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_r     <= '0;
      ack_r    <= '0;
      byte_r   <= '0;
      nib_only <= 1'b0;
      hi_phase <= 1'b0;
      wsel     <= W_40;
      idx      <= '0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_d    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_sel != 5'b00000) begin
            op_r <= req_sel;
            if (req_sel[4]) begin
              state  <= S_WAIT;
              cnt    <= L_PWR;
              idx    <= 4'd0;
              lcd_rs <= 1'b0;
              lcd_d  <= 4'h0;
            end else begin
              state    <= S_SETUP;
              cnt      <= L_SU;
              byte_r   <= ld_byte;
              nib_only <= 1'b0;
              hi_phase <= 1'b1;
              wsel     <= ld_wsel;
              lcd_rs   <= ld_rs;
              lcd_d    <= ld_byte[7:4];
            end
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            state <= S_EHIGH;
            cnt   <= L_EH;
            lcd_e <= 1'b1;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        S_EHIGH: begin
          if (cnt == '0) begin
            state <= S_GAP;
            cnt   <= L_NIB;
            lcd_e <= 1'b0;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            if (hi_phase && !nib_only) begin
              state    <= S_SETUP;
              cnt      <= L_SU;
              hi_phase <= 1'b0;
              lcd_d    <= byte_r[3:0];
            end else begin
              state <= S_WAIT;
              cnt   <= wait_load(wsel);
            end
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            if (op_r[4] && !idx[3]) begin
              state    <= S_SETUP;
              cnt      <= L_SU;
              idx      <= idx + 4'd1;
              byte_r   <= ld_byte;
              nib_only <= ld_nib;
              hi_phase <= 1'b1;
              wsel     <= ld_wsel;
              lcd_rs   <= 1'b0;
              lcd_d    <= ld_nib ? ld_byte[3:0] : ld_byte[7:4];
            end else begin
              state <= S_ACK;
              ack_r <= op_r;
            end
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        S_ACK: begin
          if (initlcd) begin
            state <= S_IDLE;
            ack_r <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign {lcdreset, lcdclear, lcdhome, lcdaddr, lcddata} = ack_r;
  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_cmd_engine.sv
module tb_lcd_cmd_engine;

  logic       CCLK = 1'b0;
  logic       debpb0 = 1'b1;
  logic       resetlcd = 1'b0, clearlcd = 1'b0, homelcd = 1'b0;
  logic       addrlcd = 1'b0, datalcd = 1'b0, initlcd = 1'b0;
  logic [7:0] lcddatin = 8'h00;
  logic       lcdreset, lcdclear, lcdhome, lcdaddr, lcddata;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  lcd_cmd_engine #(
    .T_PWR(20), .T_4100(10), .T_100(6), .T_40(4), .T_1640(8),
    .T_SU(2), .T_EH(3), .T_NIB(2)
  ) dut (
    .CCLK(CCLK), .debpb0(debpb0),
    .resetlcd(resetlcd), .clearlcd(clearlcd), .homelcd(homelcd),
    .addrlcd(addrlcd), .datalcd(datalcd), .initlcd(initlcd),
    .lcddatin(lcddatin),
    .lcdreset(lcdreset), .lcdclear(lcdclear), .lcdhome(lcdhome),
    .lcdaddr(lcdaddr), .lcddata(lcddata),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d)
  );

  always #5 CCLK = ~CCLK;

  // kind 0: E rising edge, val = {rs, d}; kind 1: ack rising, val = ack vector.
  // gap = cycles since the previous observed event, or since acceptance if fs.
  typedef struct packed {
    logic       kind;
    logic [4:0] val;
    int         gap;
    logic       fs;
  } exp_t;

  exp_t       expq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         last_cyc = 0;
  int         rise_cyc = 0;
  logic       aborting = 1'b0;
  logic       e_q = 1'b0;
  logic [4:0] acks_q = 5'b0;
  logic [4:0] acks;

  assign acks = {lcdreset, lcdclear, lcdhome, lcdaddr, lcddata};

  always @(posedge CCLK) cyc++;

  function automatic void exp_e(input logic rs, input logic [3:0] d, input int gap, input logic fs);
    exp_t e;
    e.kind = 1'b0; e.val = {rs, d}; e.gap = gap; e.fs = fs;
    expq.push_back(e);
  endfunction

  function automatic void exp_ack(input logic [4:0] a, input int gap);
    exp_t e;
    e.kind = 1'b1; e.val = a; e.gap = gap; e.fs = 1'b0;
    expq.push_back(e);
  endfunction

  task automatic check_event(input logic kind, input logic [4:0] val);
    exp_t e;
    int   g;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d got=%h at cycle %0d", kind, val, cyc);
    end else begin
      e = expq.pop_front();
      g = cyc - (e.fs ? start_cyc : last_cyc);
      if (e.kind !== kind || e.val !== val || e.gap != g) begin
        errors++;
        $display("FAIL event kind=%0d got=%h gap=%0d, required kind=%0d val=%h gap=%0d",
                 kind, val, g, e.kind, e.val, e.gap);
      end
    end
    last_cyc = cyc;
  endtask

  // Monitor: compares every E pulse and ack rise against the scoreboard queue.
  always @(negedge CCLK) begin
    if (lcd_e && !e_q) begin
      rise_cyc = cyc;
      check_event(1'b0, {lcd_rs, lcd_d});
    end
    if (!lcd_e && e_q && !aborting) begin
      checks++;
      if (cyc - rise_cyc != 3) begin
        errors++;
        $display("FAIL e_width got=%0d required=3", cyc - rise_cyc);
      end
    end
    if (acks != 5'b0 && acks_q == 5'b0) check_event(1'b1, acks);
    e_q    = lcd_e;
    acks_q = acks;
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic issue(input logic [4:0] req, input logic [7:0] b);
    @(posedge CCLK); #1;
    lcddatin = b;
    {resetlcd, clearlcd, homelcd, addrlcd, datalcd} = req;
    start_cyc = cyc + 1;
    @(posedge CCLK); #1;
    {resetlcd, clearlcd, homelcd, addrlcd, datalcd} = 5'b0;
    lcddatin = 8'hff;
  endtask

  task automatic wait_ack(input int max);
    int n = 0;
    while (acks == 5'b0 && n < max) begin
      @(negedge CCLK);
      n++;
    end
    checks++;
    if (acks == 5'b0) begin
      errors++;
      $display("FAIL ack_timeout got=0 required=ack within %0d cycles", max);
    end
  endtask

  task automatic hold_ack(input logic [4:0] a);
    for (int i = 0; i < 3; i++) begin
      @(negedge CCLK);
      check("ack_hold", int'(acks), int'(a));
    end
  endtask

  task automatic release_ack();
    @(posedge CCLK); #1 initlcd = 1'b1;
    @(posedge CCLK); #1 initlcd = 1'b0;
    @(negedge CCLK);
    check("ack_release", int'(acks), 0);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge CCLK);
    #1 debpb0 = 1'b0;
    @(negedge CCLK);
    check("rst_acks", int'(acks), 0);
    check("rst_e", int'(lcd_e), 0);
    check("rst_rs", int'(lcd_rs), 0);
    check("rst_d", int'(lcd_d), 0);
    check("rw_low", int'(lcd_rw), 0);

    // data write 'A'
    exp_e(1'b1, 4'h4, 2, 1'b1); exp_e(1'b1, 4'h1, 7, 1'b0); exp_ack(5'b00001, 9);
    issue(5'b00001, 8'h41);
    wait_ack(60);
    hold_ack(5'b00001);
    release_ack();

    // set address 0x05 -> 0x85
    exp_e(1'b0, 4'h8, 2, 1'b1); exp_e(1'b0, 4'h5, 7, 1'b0); exp_ack(5'b00010, 9);
    issue(5'b00010, 8'h05);
    wait_ack(60);
    hold_ack(5'b00010);
    release_ack();

    // power-on init sequence
    exp_e(1'b0, 4'h3, 22, 1'b1);
    exp_e(1'b0, 4'h3, 17, 1'b0);
    exp_e(1'b0, 4'h3, 13, 1'b0);
    exp_e(1'b0, 4'h2, 11, 1'b0);
    exp_e(1'b0, 4'h2, 11, 1'b0); exp_e(1'b0, 4'h8, 7, 1'b0);
    exp_e(1'b0, 4'h0, 11, 1'b0); exp_e(1'b0, 4'h6, 7, 1'b0);
    exp_e(1'b0, 4'h0, 11, 1'b0); exp_e(1'b0, 4'hC, 7, 1'b0);
    exp_e(1'b0, 4'h0, 11, 1'b0); exp_e(1'b0, 4'h1, 7, 1'b0);
    exp_ack(5'b10000, 13);
    issue(5'b10000, 8'h00);
    wait_ack(400);
    hold_ack(5'b10000);
    release_ack();

    // clear and data together: clear wins
    exp_e(1'b0, 4'h0, 2, 1'b1); exp_e(1'b0, 4'h1, 7, 1'b0); exp_ack(5'b01000, 13);
    issue(5'b01001, 8'h41);
    wait_ack(80);
    hold_ack(5'b01000);
    release_ack();

    // reset during E high of a data write, then a clean home
    exp_e(1'b1, 4'h4, 2, 1'b1);
    issue(5'b00001, 8'h41);
    repeat (2) @(posedge CCLK);
    #1 aborting = 1'b1; debpb0 = 1'b1;
    @(posedge CCLK); #1 debpb0 = 1'b0;
    @(negedge CCLK);
    check("abort_e", int'(lcd_e), 0);
    check("abort_acks", int'(acks), 0);
    check("abort_q", expq.size(), 0);
    repeat (3) @(posedge CCLK);
    #1 aborting = 1'b0;
    exp_e(1'b0, 4'h0, 2, 1'b1); exp_e(1'b0, 4'h2, 7, 1'b0); exp_ack(5'b00100, 13);
    issue(5'b00100, 8'h00);
    wait_ack(80);
    hold_ack(5'b00100);
    release_ack();

    // initlcd mid-command and datalcd during ACK are ignored
    exp_e(1'b1, 4'h5, 2, 1'b1); exp_e(1'b1, 4'hA, 7, 1'b0); exp_ack(5'b00001, 9);
    issue(5'b00001, 8'h5A);
    repeat (6) @(posedge CCLK);
    #1 initlcd = 1'b1;
    @(posedge CCLK); #1 initlcd = 1'b0;
    wait_ack(60);
    @(posedge CCLK); #1 datalcd = 1'b1;
    @(posedge CCLK); #1 datalcd = 1'b0;
    hold_ack(5'b00001);
    release_ack();

    repeat (20) @(posedge CCLK);
    @(negedge CCLK);
    check("queue_empty", expq.size(), 0);
    check("idle_acks", int'(acks), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
